// File: rtl/axi_cmd_master_pkg.sv
// Shared types and constants for the AXI command master.
// Holds the controller state encoding, AXI burst/response codes and the
// 4 KB address boundary used by the optional boundary check.
package axi_cmd_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned BOUNDARY_4K = 4096;

  // Worst (numerically largest) of two AXI response codes.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_cmd_master_fifo.sv
// Small synchronous FIFO buffering returned read beats.
// DEPTH must be a power of two so the pointers wrap naturally.
// A push is accepted at full when a pop happens in the same cycle.
module axi_cmd_master_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  // Advance pointers and occupancy for this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI4 burst master driven by a simple command port.
// Writes stream data from wd_*, reads return through a buffer on rd_*,
// and each command ends with a one-cycle done pulse carrying the worst
// response. Optional feature: define AXI_CMD_MASTER_4K_CHECK_EN to reject
// bursts crossing a 4 KB boundary (no AXI traffic, SLVERR completion,
// write data still drained).
module axi_cmd_master
  import axi_cmd_master_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ID_VALUE   = 0,
  parameter int RD_FIFO_DEPTH  = 4
) (
  input  logic                        m_axi_clk,
  input  logic                        m_axi_rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_LEN_WIDTH-1:0]    cmd_len,
  input  logic [2:0]                  cmd_size,
  input  logic                        wd_valid,
  output logic                        wd_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   wd_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] wd_strb,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data,
  output logic                        rd_last,
  output logic                        done_valid,
  output logic [1:0]                  done_resp,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]    m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]    m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic                        m_axi_arlock,
  output logic [3:0]                  m_axi_arcache,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arqos,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int         DB       = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DB));
  localparam int         CNT_W    = $clog2(RD_FIFO_DEPTH) + 1;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_LEN_WIDTH-1:0]    len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [AXI_LEN_WIDTH-1:0]    beat_q, beat_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        rlast_seen_q, rlast_seen_d;
  logic                        discard_q, discard_d;

  logic [2:0]                  size_clamped;
  logic                        over_4k;
  logic                        w_fire;
  logic                        r_push;
  logic                        fifo_full, fifo_empty;
  logic [CNT_W-1:0]            fifo_count;
  logic [AXI_DATA_WIDTH:0]     fifo_dout;
  logic                        unused_ok;

  assign unused_ok = ^{m_axi_bid, m_axi_rid, fifo_count};

  assign cmd_ready     = (state_q == S_IDLE) && !m_axi_rst;

  assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = (state_q == S_AW) ? BURST_INCR : BURST_FIXED;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = (state_q == S_AW);

  assign w_fire        = (state_q == S_W) && wd_valid && (discard_q || m_axi_wready);
  assign wd_ready      = (state_q == S_W) && (discard_q || m_axi_wready);
  assign m_axi_wvalid  = (state_q == S_W) && !discard_q && wd_valid;
  assign m_axi_wdata   = wd_data;
  assign m_axi_wstrb   = wd_strb;
  assign m_axi_wlast   = (state_q == S_W) && (beat_q == len_q);

  assign m_axi_bready  = (state_q == S_B);

  assign m_axi_arid    = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = (state_q == S_AR) ? BURST_INCR : BURST_FIXED;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = (state_q == S_AR);

  assign m_axi_rready  = (state_q == S_R) && !rlast_seen_q && !fifo_full;
  assign r_push        = m_axi_rvalid && m_axi_rready;

  assign rd_valid      = !fifo_empty;
  assign rd_data       = fifo_dout[AXI_DATA_WIDTH-1:0];
  assign rd_last       = fifo_dout[AXI_DATA_WIDTH];

  assign done_valid    = (state_q == S_DONE);
  assign done_resp     = resp_q;

  axi_cmd_master_fifo #(
    .DEPTH (RD_FIFO_DEPTH),
    .WIDTH (AXI_DATA_WIDTH + 1)
  ) u_rd_fifo (
    .clk       (m_axi_clk),
    .rst       (m_axi_rst),
    .push      (r_push),
    .push_data ({m_axi_rlast, m_axi_rdata}),
    .pop       (rd_ready),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Clamp the beat size to the bus width and flag bursts crossing 4 KB.
  always_comb begin
    size_clamped = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
`ifdef AXI_CMD_MASTER_4K_CHECK_EN
    over_4k = (32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << size_clamped))
              > 32'(BOUNDARY_4K);
`else
    over_4k = 1'b0;
`endif
  end

  // Command sequencing: next state plus latched command and response.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    beat_d       = beat_q;
    resp_d       = resp_q;
    rlast_seen_d = rlast_seen_q;
    discard_d    = discard_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d       = cmd_addr;
          len_d        = cmd_len;
          size_d       = size_clamped;
          beat_d       = '0;
          resp_d       = RESP_OKAY;
          rlast_seen_d = 1'b0;
          discard_d    = over_4k;
          if (over_4k) begin
            resp_d  = RESP_SLVERR;
            state_d = cmd_write ? S_W : S_DONE;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_AR: if (m_axi_arready) state_d = S_R;
      S_W: begin
        if (w_fire) begin
          if (beat_q == len_q) state_d = discard_q ? S_DONE : S_B;
          else                 beat_d  = beat_q + AXI_LEN_WIDTH'(1);
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          state_d = S_DONE;
        end
      end
      S_R: begin
        if (r_push) begin
          resp_d = resp_max(resp_q, m_axi_rresp);
          if (m_axi_rlast) rlast_seen_d = 1'b1;
        end
        if (rlast_seen_q && fifo_empty) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and command registers; reset abandons any transaction.
  always_ff @(posedge m_axi_clk or posedge m_axi_rst) begin
    if (m_axi_rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      beat_q       <= '0;
      resp_q       <= RESP_OKAY;
      rlast_seen_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      beat_q       <= beat_d;
      resp_q       <= resp_d;
      rlast_seen_q <= rlast_seen_d;
      discard_q    <= discard_d;
    end
  end

endmodule
